// File: rtl/id_ex_stage.sv
// ID/EX stage boundary for the pipelined RV32I core: register-file address
// generation, WB bypass, x0 forcing, immediate decode, load-use hazard
// detection and the ID/EX pipeline register with flush/hold/stall control.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter bit FORCE_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ext_hold,
  input  logic            flush,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_mem_read,
  output logic            ex_reg_write
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign rf_a1  = rs1;
  assign rf_a2  = rs2;

  // Decoded control
  logic [XLEN-1:0] imm;
  logic            uses_rs1, uses_rs2, writes_rd, is_load;
  logic [XLEN-1:0] op1, op2;

  // EX register state
  logic            valid_q, valid_d;
  logic            mem_read_q, mem_read_d;
  logic            reg_write_q, reg_write_d;
  logic [XLEN-1:0] pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7b5_q, funct7b5_d;

  // Operand source: x0 forced to zero, then same-cycle WB write-through, then RF.
  function automatic logic [XLEN-1:0] sel_operand(input logic [4:0]      rs,
                                                  input logic [XLEN-1:0] rf_data,
                                                  input logic            we,
                                                  input logic [4:0]      wa,
                                                  input logic [XLEN-1:0] wd);
    if (FORCE_X0 && rs == 5'd0)   return '0;
    else if (we && wa == rs)      return wd;
    else                          return rf_data;
  endfunction

  assign op1 = sel_operand(rs1, rf_rd1, wb_en, wb_addr, wb_data);
  assign op2 = sel_operand(rs2, rf_rd2, wb_en, wb_addr, wb_data);

  // Immediate generation and register-usage decode by opcode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    imm       = '0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    unique case (opcode)
      OP_IMM, OP_JALR: begin
        imm       = {{20{id_instr[31]}}, id_instr[31:20]};
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        imm       = {{20{id_instr[31]}}, id_instr[31:20]};
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_STORE: begin
        imm      = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                    id_instr[30:25], id_instr[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm       = {id_instr[31:12], 12'b0};
        uses_rs1  = 1'b0;
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm       = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                     id_instr[20], id_instr[30:21], 1'b0};
        uses_rs1  = 1'b0;
        writes_rd = 1'b1;
      end
      OP_REG: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use hazard: a load in EX feeds a source register read in ID.
  assign stall_id = id_valid & valid_q & mem_read_q & (rd_q != 5'd0) &
                    ((uses_rs1 & (rd_q == rs1)) | (uses_rs2 & (rd_q == rs2))) &
                    ~flush & ~ext_hold;

  // EX register next state: flush > hold > stall bubble > capture.
  always_comb begin
    valid_d     = valid_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    pc_d        = pc_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    funct7b5_d  = funct7b5_q;
    if (flush || (!ext_hold && stall_id)) begin
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (!ext_hold) begin
      valid_d     = id_valid;
      mem_read_d  = id_valid & is_load;
      reg_write_d = id_valid & writes_rd & (rd != 5'd0);
      pc_d        = id_pc;
      op1_d       = op1;
      op2_d       = op2;
      imm_d       = imm;
      rs1_d       = rs1;
      rs2_d       = rs2;
      rd_d        = rd;
      opcode_d    = opcode;
      funct3_d    = funct3;
      funct7b5_d  = id_instr[30];
    end
  end

  // EX pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      pc_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7b5_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q     <= valid_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
      pc_q        <= pc_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7b5_q  <= funct7b5_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign ex_pc        = pc_q;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_opcode    = opcode_q;
  assign ex_funct3    = funct3_q;
  assign ex_funct7b5  = funct7b5_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when an
// instruction is driven into ID and compared one cycle later.
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ext_hold, flush, stall_id;
  logic        ex_valid, ex_funct7b5, ex_mem_read, ex_reg_write;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        full;
    logic        valid, mem_read, reg_write;
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
  } exp_t;

  exp_t sb[$];

  id_ex_stage #(.XLEN(32), .FORCE_X0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ext_hold(ext_hold), .flush(flush), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2, r1,
                                        input logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2, r1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, pc, rd1, rd2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic hold, fl);
    id_valid = v;  id_instr = ins; id_pc = pc;  rf_rd1 = rd1; rf_rd2 = rd2;
    wb_en = we;    wb_addr = wa;   wb_data = wd; ext_hold = hold; flush = fl;
    #1;
  endtask

  task automatic expect_full(input logic [31:0] ins, pc, op1, op2, imm,
                             input logic v, mr, rw);
    exp_t e;
    e.full = 1'b1; e.valid = v; e.mem_read = mr; e.reg_write = rw;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.opcode = ins[6:0]; e.funct3 = ins[14:12]; e.f7b5 = ins[30];
    sb.push_back(e);
  endtask

  task automatic expect_bubble();
    exp_t e;
    e = '{default: '0};
    sb.push_back(e);
  endtask

  // One clock: sample registered outputs after the edge, compare to queue head.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, ex_valid, e.valid);
      check({tag, "_mem_read"}, ex_mem_read, e.mem_read);
      check({tag, "_reg_write"}, ex_reg_write, e.reg_write);
      if (e.full) begin
        check({tag, "_pc"}, ex_pc, e.pc);
        check({tag, "_op1"}, ex_op1, e.op1);
        check({tag, "_op2"}, ex_op2, e.op2);
        check({tag, "_imm"}, ex_imm, e.imm);
        check({tag, "_rs1"}, ex_rs1, e.rs1);
        check({tag, "_rs2"}, ex_rs2, e.rs2);
        check({tag, "_rd"}, ex_rd, e.rd);
        check({tag, "_opcode"}, ex_opcode, e.opcode);
        check({tag, "_funct3"}, ex_funct3, e.funct3);
        check({tag, "_f7b5"}, ex_funct7b5, e.f7b5);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, ex_valid, 0);
    check({tag, "_pc"}, ex_pc, 0);
    check({tag, "_op1"}, ex_op1, 0);
    check({tag, "_op2"}, ex_op2, 0);
    check({tag, "_imm"}, ex_imm, 0);
    check({tag, "_rs1"}, ex_rs1, 0);
    check({tag, "_rs2"}, ex_rs2, 0);
    check({tag, "_rd"}, ex_rd, 0);
    check({tag, "_opcode"}, ex_opcode, 0);
    check({tag, "_funct3"}, ex_funct3, 0);
    check({tag, "_f7b5"}, ex_funct7b5, 0);
    check({tag, "_mem_read"}, ex_mem_read, 0);
    check({tag, "_reg_write"}, ex_reg_write, 0);
    check({tag, "_stall"}, stall_id, 0);
  endtask

  initial begin
    logic [31:0] ins;

    // Reset with random inputs
    rst_n = 1'b0;
    drive(1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1, 5'($urandom), $urandom, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,5: x0 forced, imm 5, rs2 field (=5) reads RF
    ins = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011);
    drive(1, ins, 32'h100, 32'h55, 32'h22, 0, 5'd0, 0, 0, 0);
    check("addi_rf_a1", rf_a1, 0);
    check("addi_rf_a2", rf_a2, 5);
    check("addi_stall", stall_id, 0);
    expect_full(ins, 32'h100, 0, 32'h22, 32'd5, 1, 0, 1);
    tick("addi");

    // ADD x4,x3,x3 with WB writing x3 in the same cycle
    ins = enc_r(7'd0, 5'd3, 5'd3, 3'd0, 5'd4);
    drive(1, ins, 32'h104, 32'h11, 32'h11, 1, 5'd3, 32'hABCD, 0, 0);
    expect_full(ins, 32'h104, 32'hABCD, 32'hABCD, 0, 1, 0, 1);
    tick("bypass");

    // SUB x7,x0,x2: x0 not bypassed even when WB targets x0
    ins = enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd7);
    drive(1, ins, 32'h108, 32'hDEADBEEF, 32'h1234, 1, 5'd0, 32'h9999, 0, 0);
    expect_full(ins, 32'h108, 0, 32'h1234, 0, 1, 0, 1);
    tick("x0force");

    // LW x5,0(x2) then ADD x6,x5,x1: one bubble, then ADD captured
    ins = enc_i(12'd0, 5'd2, 3'd2, 5'd5, 7'b0000011);
    drive(1, ins, 32'h10C, 32'h2000, 32'h0, 0, 5'd0, 0, 0, 0);
    check("lw_stall", stall_id, 0);
    expect_full(ins, 32'h10C, 32'h2000, 32'h0, 0, 1, 1, 1);
    tick("lw");
    ins = enc_r(7'd0, 5'd1, 5'd5, 3'd0, 5'd6);
    drive(1, ins, 32'h110, 32'h5555, 32'h1111, 0, 5'd0, 0, 0, 0);
    check("loaduse_stall", stall_id, 1);
    expect_bubble();
    tick("loaduse_bubble");
    check("loaduse_stall_end", stall_id, 0);
    expect_full(ins, 32'h110, 32'h5555, 32'h1111, 0, 1, 0, 1);
    tick("loaduse_add");

    // Flush beats hold and hazard
    ins = enc_i(12'd4, 5'd2, 3'd2, 5'd5, 7'b0000011);
    drive(1, ins, 32'h114, 32'h2000, 32'h0, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h114, 32'h2000, 32'h0, 32'd4, 1, 1, 1);
    tick("lw2");
    ins = enc_r(7'd0, 5'd1, 5'd5, 3'd0, 5'd6);
    drive(1, ins, 32'h118, 32'h1, 32'h2, 0, 5'd0, 0, 1, 1);
    check("flush_stall", stall_id, 0);
    expect_bubble();
    tick("flush");

    // BEQ x1,x2,-8
    ins = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0);
    drive(1, ins, 32'h120, 32'hA1, 32'hA2, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h120, 32'hA1, 32'hA2, 32'hFFFFFFF8, 1, 0, 0);
    tick("beq");

    // Hold: EX keeps BEQ while LUI waits in ID
    ins = enc_u(20'h12345, 5'd8, 7'b0110111);
    drive(1, ins, 32'h124, 32'hB1, 32'hB2, 0, 5'd0, 0, 1, 0);
    check("hold_stall", stall_id, 0);
    expect_full(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h120, 32'hA1, 32'hA2,
                32'hFFFFFFF8, 1, 0, 0);
    tick("hold");

    // LUI x8,0x12345 (rs fields are 8 and 3, read from RF)
    drive(1, ins, 32'h124, 32'hB1, 32'hB2, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h124, 32'hB1, 32'hB2, 32'h12345000, 1, 0, 1);
    tick("lui");

    // JAL x1,+0x800 (rs1 field 0 forced, rs2 field 1)
    ins = enc_j(21'h000800, 5'd1);
    drive(1, ins, 32'h128, 32'hC1, 32'hC2, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h128, 0, 32'hC2, 32'h00000800, 1, 0, 1);
    tick("jal");

    // SW x3,-4(x2)
    ins = enc_s(12'hFFC, 5'd3, 5'd2, 3'd2);
    drive(1, ins, 32'h12C, 32'hD1, 32'hD2, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h12C, 32'hD1, 32'hD2, 32'hFFFFFFFC, 1, 0, 0);
    tick("sw");

    // Load to x0 never causes a stall
    ins = enc_i(12'd0, 5'd2, 3'd2, 5'd0, 7'b0000011);
    drive(1, ins, 32'h130, 32'h3000, 32'h0, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h130, 32'h3000, 32'h0, 0, 1, 1, 0);
    tick("lw_x0");
    ins = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd6);
    drive(1, ins, 32'h134, 32'hE1, 32'hE2, 0, 5'd0, 0, 0, 0);
    check("lw_x0_stall", stall_id, 0);
    expect_full(ins, 32'h134, 0, 0, 0, 1, 0, 1);
    tick("add_x0");

    // Reset asserted during an rs2 load-use stall
    ins = enc_i(12'd0, 5'd2, 3'd2, 5'd9, 7'b0000011);
    drive(1, ins, 32'h138, 32'h4000, 32'h0, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h138, 32'h4000, 32'h0, 0, 1, 1, 1);
    tick("lw_x9");
    ins = enc_r(7'd0, 5'd9, 5'd1, 3'd0, 5'd10);
    drive(1, ins, 32'h13C, 32'hF1, 32'hF2, 0, 5'd0, 0, 0, 0);
    check("rs2_hazard_stall", stall_id, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x0,x1,1: valid but no register write
    ins = enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'b0010011);
    drive(1, ins, 32'h140, 32'h7, 32'h8, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h140, 32'h7, 32'h8, 32'd1, 1, 0, 0);
    tick("addi_x0");

    // Invalid ID slot
    drive(0, ins, 32'h144, 32'h7, 32'h8, 0, 5'd0, 0, 0, 0);
    expect_full(ins, 32'h144, 32'h7, 32'h8, 32'd1, 0, 0, 0);
    tick("invalid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute stage boundary of the pipelined RV32I core.
- Drives register-file read addresses from the IF/ID instruction and consumes the asynchronous read data.
- Applies WB-to-ID write-through bypass, forces x0 to zero, and generates immediates.
- Detects load-use hazards and registers all operands and control into the ID/EX pipeline register, with stall, hold and flush support.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- FORCE_X0, 1, when 1 an operand read from x0 is forced to 0. Required because the register file has no reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  32  instruction in ID
- id_pc  in  32  PC of id_instr
- rf_a1  out  5  register file read address 1; combinational, equals id_instr[19:15]
- rf_a2  out  5  register file read address 2; combinational, equals id_instr[24:20]
- rf_rd1  in  32  register file read data 1 (asynchronous)
- rf_rd2  in  32  register file read data 2 (asynchronous)
- wb_en  in  1  WB write enable; same signal that drives the register file WriteEn
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- ext_hold  in  1  downstream stall; freezes the EX register
- flush  in  1  redirect from EX (taken branch/jump); kills the instruction entering EX
- stall_id  out  1  combinational; holds IF and IF/ID this cycle
- ex_valid  out  1  EX register holds a live instruction
- ex_pc  out  32  registered PC
- ex_op1  out  32  registered rs1 operand
- ex_op2  out  32  registered rs2 operand
- ex_imm  out  32  registered sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
- ex_opcode  out  7  registered opcode
- ex_funct3  out  3  registered funct3
- ex_funct7b5  out  1  registered instr[30]
- ex_mem_read  out  1  registered; instruction is a load
- ex_reg_write  out  1  registered; instruction writes a nonzero rd

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0; stall_id evaluates to 0.
- Latency: exactly 1 cycle from ID to the EX outputs.
- Operand selection, per source (rs1/rf_rd1 shown; rs2 identical):
  - if FORCE_X0 and rs1==0: 0
  - else if wb_en and wb_addr==rs1: wb_data (bypass)
  - else rf_rd1
- Immediate generation by opcode:
  - I (0010011, 0000011, 1100111): sign-extended instr[31:20]
  - S (0100011), B (1100011), U (0110111, 0010111), J (1101111): standard RV32I formats; B and J immediates have bit 0 = 0
  - R and unknown opcodes: 0
- Register usage:
  - uses_rs1: every opcode except LUI, AUIPC, JAL.
  - uses_rs2: R (0110011), S, B only.
  - writes_rd: R, I-ALU, load, LUI, AUIPC, JAL, JALR.
- Load-use hazard: stall_id = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)) & !flush & !ext_hold.
- EX register update on rising clk, priority order:
  1. flush: ex_valid, ex_mem_read, ex_reg_write <= 0; other fields don't-care.
  2. ext_hold: all EX registers unchanged.
  3. stall_id: bubble; ex_valid, ex_mem_read, ex_reg_write <= 0.
  4. Otherwise: capture all fields. ex_valid <= id_valid; ex_mem_read <= id_valid & load; ex_reg_write <= id_valid & writes_rd & (rd!=0).
- A load-use stall lasts exactly one cycle: the bubble clears ex_mem_read.
- Simultaneous flush and hazard: flush wins and stall_id stays 0.
- Simultaneous WB write and ID read of the same register: the bypass supplies the new value.
- Reset asserted mid-stall: outputs clear immediately and the stall ends.

Test Plan:
- Reset: rst_n=0 with random inputs -> all ex_* = 0 and stall_id = 0; release -> first valid ADDI x1,x0,5 appears next cycle with ex_op1=0, ex_imm=5, ex_reg_write=1.
- Bypass: rf_rd1=0x11, wb_en=1, wb_addr=3, wb_data=0xABCD, id_instr=ADD x4,x3,x3 -> ex_op1 = ex_op2 = 0xABCD.
- x0 forcing: rf_rd1=0xDEADBEEF, instruction reads x0, wb_en=1, wb_addr=0 -> ex_op1=0.
- Load-use: LW x5,0(x2) in EX, ADD x6,x5,x1 in ID -> stall_id=1 for one cycle, next ex_valid=0, then ADD is captured with stall_id=0.
- Flush priority: flush=1 together with a load-use condition and ext_hold=1 -> stall_id=0; next cycle ex_valid=0, ex_reg_write=0.
- Immediates: BEQ with offset -8 -> ex_imm=0xFFFFFFF8; LUI 0x12345 -> 0x12345000; JAL with offset 0x800 -> 0x00000800.
